// File: rtl/fpmul_core_seq.sv
// Sequential binary32 multiplier core: shift-add significand product, normalize,
// optional round-to-nearest-even (FPMUL_ROUND_NEAREST_EN), exception flags.
module fpmul_core_seq #(
  parameter int BIAS = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [24:0] final_product,
  output logic [8:0]  final_exponent,
  output logic        new_sign,
  output logic        exception1,
  output logic        exception2
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_NORM = 3'd2;
  localparam logic [2:0] S_RND  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [47:0]        acc_q, acc_d;
  logic [23:0]        mcand_q, mcand_d;
  logic signed [9:0]  esum_q, esum_d;
  logic               sign_q, sign_d;
  logic               exc1_q, exc1_d;
  logic               zero_q, zero_d;

  logic [24:0]        prod_q, prod_d;
  logic [8:0]         fexp_q, fexp_d;
  logic               nsign_q, nsign_d;
  logic               e1_q, e1_d;
  logic               e2_q, e2_d;

  logic [23:0]        norm_sig;
  logic signed [9:0]  norm_exp;
  logic [23:0]        fin_sig;
  logic signed [9:0]  fin_exp;
  logic [24:0]        add_sum;
  logic               a_zero, b_zero, range_bad;

`ifdef FPMUL_ROUND_NEAREST_EN
  logic [23:0]        sig_q, sig_d;
  logic               guard_q, guard_d;
  logic               sticky_q, sticky_d;
  logic               norm_guard, norm_sticky;
  logic [24:0]        rnd_sum;
`endif

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign final_product  = prod_q;
  assign final_exponent = fexp_q;
  assign new_sign       = nsign_q;
  assign exception1     = e1_q;
  assign exception2     = e2_q;

  assign a_zero  = (a[30:23] == 8'd0);
  assign b_zero  = (b[30:23] == 8'd0);
  // acc[23:0] doubles as the multiplier shift register; its LSB gates the add.
  assign add_sum = {1'b0, acc_q[47:24]} + (acc_q[0] ? {1'b0, mcand_q} : 25'd0);

  always_comb begin
    norm_sig = acc_q[46:23];
    norm_exp = esum_q;
`ifdef FPMUL_ROUND_NEAREST_EN
    norm_guard  = acc_q[22];
    norm_sticky = |acc_q[21:0];
`endif
    if (acc_q[47]) begin
      norm_sig = acc_q[47:24];
      norm_exp = esum_q + 10'sd1;
`ifdef FPMUL_ROUND_NEAREST_EN
      norm_guard  = acc_q[23];
      norm_sticky = |acc_q[22:0];
`endif
    end
  end

`ifdef FPMUL_ROUND_NEAREST_EN
  always_comb begin
    rnd_sum = {1'b0, sig_q} + {24'd0, guard_q & (sticky_q | sig_q[0])};
    fin_sig = rnd_sum[23:0];
    fin_exp = esum_q;
    if (rnd_sum[24]) begin
      fin_sig = rnd_sum[24:1];
      fin_exp = esum_q + 10'sd1;
    end
  end
`else
  assign fin_sig = norm_sig;
  assign fin_exp = norm_exp;
`endif

  assign range_bad = (fin_exp <= 10'sd0) || (fin_exp >= 10'sd255);

  // NOTE: every next-state signal gets a default first, so no path through the
  // case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    esum_d  = esum_q;
    sign_d  = sign_q;
    exc1_d  = exc1_q;
    zero_d  = zero_q;
    prod_d  = prod_q;
    fexp_d  = fexp_q;
    nsign_d = nsign_q;
    e1_d    = e1_q;
    e2_d    = e2_q;
`ifdef FPMUL_ROUND_NEAREST_EN
    sig_d    = sig_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d = a_zero ? 24'd0 : {1'b1, a[22:0]};
          acc_d   = {24'd0, (b_zero ? 24'd0 : {1'b1, b[22:0]})};
          esum_d  = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'(BIAS);
          sign_d  = a[31] ^ b[31];
          exc1_d  = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
          zero_d  = a_zero || b_zero;
          cnt_d   = 5'd0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        acc_d = {add_sum, acc_q[23:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd23) state_d = S_NORM;
      end
`ifdef FPMUL_ROUND_NEAREST_EN
      S_NORM: begin
        sig_d    = norm_sig;
        guard_d  = norm_guard;
        sticky_d = norm_sticky;
        esum_d   = norm_exp;
        state_d  = S_RND;
      end
      S_RND: state_d = S_DONE;
`else
      S_NORM: state_d = S_DONE;
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Result registers load on the edge into DONE; priority: Inf/NaN, zero, range.
    if (state_d == S_DONE && state_q != S_DONE) begin
      nsign_d = sign_q;
      e1_d    = exc1_q;
      e2_d    = !exc1_q && !zero_q && range_bad;
      prod_d  = 25'd0;
      fexp_d  = 9'd0;
      if (!exc1_q && !zero_q && !range_bad) begin
        prod_d = {1'b0, fin_sig};
        fexp_d = fin_exp[8:0];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      esum_q  <= '0;
      sign_q  <= 1'b0;
      exc1_q  <= 1'b0;
      zero_q  <= 1'b0;
      prod_q  <= '0;
      fexp_q  <= '0;
      nsign_q <= 1'b0;
      e1_q    <= 1'b0;
      e2_q    <= 1'b0;
`ifdef FPMUL_ROUND_NEAREST_EN
      sig_q    <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      esum_q  <= esum_d;
      sign_q  <= sign_d;
      exc1_q  <= exc1_d;
      zero_q  <= zero_d;
      prod_q  <= prod_d;
      fexp_q  <= fexp_d;
      nsign_q <= nsign_d;
      e1_q    <= e1_d;
      e2_q    <= e2_d;
`ifdef FPMUL_ROUND_NEAREST_EN
      sig_q    <= sig_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
`endif
    end
  end

endmodule

// File: tb/tb_fpmul_core_seq.sv
// Self-checking bench for fpmul_core_seq: directed and random operands checked
// through an expected-result queue, plus latency, busy/done, abort and boundary cases.
module tb_fpmul_core_seq;

  typedef struct packed {
    logic [24:0] prod;
    logic [8:0]  expo;
    logic        sign;
    logic        e1;
    logic        e2;
  } res_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    res_t        r;
  } vec_t;

`ifdef FPMUL_ROUND_NEAREST_EN
  localparam int LAT = 27;
`else
  localparam int LAT = 26;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [24:0] final_product;
  logic [8:0]  final_exponent;
  logic        new_sign, exception1, exception2;

  int checks = 0;
  int errors = 0;
  res_t exp_q[$];

  fpmul_core_seq #(.BIAS(127)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done),
    .final_product(final_product), .final_exponent(final_exponent),
    .new_sign(new_sign), .exception1(exception1), .exception2(exception2)
  );

  always #5 clk = ~clk;

  function automatic res_t dut_out();
    res_t r;
    r.prod = final_product;
    r.expo = final_exponent;
    r.sign = new_sign;
    r.e1   = exception1;
    r.e2   = exception2;
    return r;
  endfunction

  // Reference: full-width product, then normalize/round on integers.
  function automatic res_t model(input logic [31:0] av, input logic [31:0] bv);
    res_t r;
    int ea, eb, e;
    logic [47:0] p;
    logic [23:0] sig;
`ifdef FPMUL_ROUND_NEAREST_EN
    logic [24:0] s25;
    logic g, st;
`endif
    r = '0;
    r.sign = av[31] ^ bv[31];
    ea = int'(av[30:23]);
    eb = int'(bv[30:23]);
    if (ea == 255 || eb == 255) begin
      r.e1 = 1'b1;
      return r;
    end
    if (ea == 0 || eb == 0) return r;
    p = {24'd0, 1'b1, av[22:0]} * {24'd0, 1'b1, bv[22:0]};
    e = ea + eb - 127;
    if (p[47]) begin
      sig = p[47:24];
      e = e + 1;
    end else begin
      sig = p[46:23];
    end
`ifdef FPMUL_ROUND_NEAREST_EN
    if (p[47]) begin g = p[23]; st = |p[22:0]; end
    else       begin g = p[22]; st = |p[21:0]; end
    if (g && (st || sig[0])) begin
      s25 = {1'b0, sig} + 25'd1;
      if (s25[24]) begin
        sig = s25[24:1];
        e = e + 1;
      end else begin
        sig = s25[23:0];
      end
    end
`endif
    if (e <= 0 || e >= 255) begin
      r.e2 = 1'b1;
      return r;
    end
    r.prod = {1'b0, sig};
    r.expo = 9'(e);
    return r;
  endfunction

  // Drives one start, optionally a stray start or a reset mid-operation, and
  // waits (bounded) for done. lat = -1 when done never arrives.
  task automatic drive_op(input logic [31:0] av, input logic [31:0] bv,
                          input int stray_at, input int rst_at,
                          output int lat, output logic busy_bad,
                          output res_t got, output res_t after, output logic after_bad);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_bad = !busy;
    while (!done && lat < 40) begin
      start = (lat == stray_at);
      if (lat == stray_at) begin a = 32'h7F800000; b = 32'h7F800000; end
      rst = (lat == rst_at);
      @(negedge clk);
      lat++;
      if (rst_at < 0 && !busy) busy_bad = 1'b1;
    end
    start = 1'b0;
    rst = 1'b0;
    got = dut_out();
    if (!done) lat = -1;
    @(negedge clk);
    after = dut_out();
    after_bad = done || busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (dut_out() !== res_t'(0) || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got out=%h busy=%b done=%b, want all 0", dut_out(), busy, done);
    end
    rst = 1'b0;
  endtask

  task automatic run_table(input string tag, input vec_t tbl[], input int stray_at);
    int lat; logic bb, ab; res_t got, after, want;
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i].r);
      drive_op(tbl[i].a, tbl[i].b, stray_at, -1, lat, bb, got, after, ab);
      want = exp_q.pop_front();
      checks++;
      if (lat !== LAT) begin
        errors++;
        $display("FAIL %s[%0d]_latency: got %0d cycles, want %0d", tag, i, lat, LAT);
      end
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s[%0d]_result a=%h b=%h: got prod=%h exp=%h s=%b e1=%b e2=%b, want prod=%h exp=%h s=%b e1=%b e2=%b",
                 tag, i, tbl[i].a, tbl[i].b, got.prod, got.expo, got.sign, got.e1, got.e2,
                 want.prod, want.expo, want.sign, want.e1, want.e2);
      end
      checks++;
      if (bb !== 1'b0 || ab !== 1'b0 || after !== got) begin
        errors++;
        $display("FAIL %s[%0d]_handshake: busy_gap=%b busy/done_after=%b held=%b, want 0 0 1",
                 tag, i, bb, ab, after === got);
      end
    end
  endtask

  function automatic vec_t mk(input logic [31:0] av, input logic [31:0] bv,
                              input logic [24:0] p, input logic [8:0] e,
                              input logic s, input logic x1, input logic x2);
    vec_t v;
    v.a = av; v.b = bv;
    v.r.prod = p; v.r.expo = e; v.r.sign = s; v.r.e1 = x1; v.r.e2 = x2;
    return v;
  endfunction

  task automatic test_arith();
    vec_t t[];
`ifdef FPMUL_ROUND_NEAREST_EN
    logic [24:0] rp = 25'h0900001;
`else
    logic [24:0] rp = 25'h0900000;
`endif
    t = new[6];
    t[0] = mk(32'h40000000, 32'h40400000, 25'h0C00000, 9'h081, 1'b0, 1'b0, 1'b0);
    t[1] = mk(32'hBFC00000, 32'h3FC00000, 25'h0900000, 9'h080, 1'b1, 1'b0, 1'b0);
    t[2] = mk(32'h3FC00001, 32'h3FC00000, rp,           9'h080, 1'b0, 1'b0, 1'b0);
    t[3] = mk(32'h3F800000, 32'h3F800000, 25'h0800000, 9'h07F, 1'b0, 1'b0, 1'b0);
    t[4] = mk(32'h7F000000, 32'h3F800000, 25'h0800000, 9'h0FE, 1'b0, 1'b0, 1'b0);
    t[5] = mk(32'h00800000, 32'hBF800000, 25'h0800000, 9'h001, 1'b1, 1'b0, 1'b0);
    run_table("arith", t, -1);
  endtask

  task automatic test_exceptions();
    vec_t t[];
    t = new[6];
    t[0] = mk(32'h7F800000, 32'h3F800000, 25'h0, 9'h0, 1'b0, 1'b1, 1'b0);
    t[1] = mk(32'h7F000000, 32'h7F000000, 25'h0, 9'h0, 1'b0, 1'b0, 1'b1);
    t[2] = mk(32'hFF800000, 32'h00000000, 25'h0, 9'h0, 1'b1, 1'b1, 1'b0);
    t[3] = mk(32'h7F400000, 32'h3FC00000, 25'h0, 9'h0, 1'b0, 1'b0, 1'b1);
    t[4] = mk(32'h00800000, 32'h3F000000, 25'h0, 9'h0, 1'b0, 1'b0, 1'b1);
    t[5] = mk(32'h00800000, 32'h00800000, 25'h0, 9'h0, 1'b0, 1'b0, 1'b1);
    run_table("exc", t, -1);
  endtask

  task automatic test_zero_and_busy_start();
    vec_t t[];
    int extra = 0;
    t = new[2];
    t[0] = mk(32'h00000000, 32'h40000000, 25'h0, 9'h0, 1'b0, 1'b0, 1'b0);
    t[1] = mk(32'h00400000, 32'hC0000000, 25'h0, 9'h0, 1'b1, 1'b0, 1'b0);
    run_table("zero_stray", t, 5);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL stray_start_ignored: got %0d extra done pulses, want 0", extra);
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic bb, ab; res_t got, after;
    drive_op(32'h40000000, 32'h40400000, -1, 10, lat, bb, got, after, ab);
    checks++;
    if (lat !== -1 || got !== res_t'(0) || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: got lat=%0d out=%h busy=%b, want no done, out 0, idle", lat, got, busy);
    end
    begin
      vec_t t[];
      t = new[1];
      t[0] = mk(32'h40000000, 32'h40400000, 25'h0C00000, 9'h081, 1'b0, 1'b0, 1'b0);
      run_table("after_abort", t, -1);
    end
  endtask

  task automatic test_random();
    vec_t t[];
    logic [31:0] av, bv;
    t = new[12];
    t[0] = mk(32'h3FFFFFFF, 32'h3F800001, '0, '0, 1'b0, 1'b0, 1'b0);
    t[1] = mk(32'h3FFFFFFF, 32'h3FFFFFFF, '0, '0, 1'b0, 1'b0, 1'b0);
    t[0].r = model(t[0].a, t[0].b);
    t[1].r = model(t[1].a, t[1].b);
    for (int i = 2; i < 12; i++) begin
      av = {1'($urandom), 8'($urandom_range(40, 214)), 23'($urandom)};
      bv = {1'($urandom), 8'($urandom_range(40, 214)), 23'($urandom)};
      t[i] = mk(av, bv, '0, '0, 1'b0, 1'b0, 1'b0);
      t[i].r = model(av, bv);
    end
    run_table("rand", t, -1);
  endtask

  initial begin
    test_reset();
    test_arith();
    test_exceptions();
    test_zero_and_busy_start();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
